// File: rtl/bram_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port BRAM with registered read data.
// Out-of-range accesses are suppressed at the memory and reported one cycle later on err_o.
module bram_port_arbiter #(
  parameter int DataWidth = 8,
  parameter int Depth     = 1024,
  localparam int AW       = $clog2(Depth) + 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [1:0]             req_i,
  input  logic [1:0]             we_i,
  input  logic [2*AW-1:0]        addr_i,
  input  logic [2*DataWidth-1:0] data_i,
  output logic [1:0]             ready_o,
  output logic [1:0]             rvalid_o,
  output logic [DataWidth-1:0]   rdata_o,
  output logic [1:0]             err_o,
  output logic                   mem_we_o,
  output logic [AW-1:0]          mem_addr_o,
  output logic [DataWidth-1:0]   mem_data_o,
  input  logic [DataWidth-1:0]   mem_data_i
);

  // Handshake: requester i transfers in any cycle where req_i[i] & ready_o[i]; req_i may be
  // withdrawn before it is granted. Each transfer yields, one cycle later, an rvalid_o pulse
  // (reads) and/or an err_o pulse (out of range); responses follow issue order.

  localparam logic [AW-1:0] DepthA = AW'(Depth);

  logic                 last_q;  // index of the requester granted on the most recent transfer
  logic [1:0]           gnt;
  logic                 sel;
  logic                 xfer;
  logic [AW-1:0]        sel_addr;
  logic [DataWidth-1:0] sel_data;
  logic                 sel_we;
  logic                 in_range;
  logic [1:0]           rd_q;
  logic [1:0]           err_q;
  logic                 oor_q;

  always_comb begin
    gnt = 2'b00;
    if (rst_ni) begin
      if (req_i == 2'b11) gnt = last_q ? 2'b01 : 2'b10;
      else                gnt = req_i;
    end
  end

  assign ready_o  = gnt;
  assign xfer     = |gnt;
  assign sel      = gnt[1];
  assign sel_addr = sel ? addr_i[2*AW-1:AW] : addr_i[AW-1:0];
  assign sel_data = sel ? data_i[2*DataWidth-1:DataWidth] : data_i[DataWidth-1:0];
  assign sel_we   = sel ? we_i[1] : we_i[0];
  assign in_range = sel_addr < DepthA;

  always_comb begin
    mem_we_o   = 1'b0;
    mem_addr_o = '0;
    mem_data_o = '0;
    if (xfer && in_range) begin
      mem_we_o   = sel_we;
      mem_addr_o = sel_addr;
      mem_data_o = sel_data;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= 1'b1;
      rd_q   <= 2'b00;
      err_q  <= 2'b00;
      oor_q  <= 1'b0;
    end else begin
      rd_q  <= (xfer && !sel_we) ? gnt : 2'b00;
      err_q <= (xfer && !in_range) ? gnt : 2'b00;
      oor_q <= xfer && !in_range;
      if (xfer) last_q <= sel;
    end
  end

  assign rvalid_o = rd_q;
  assign err_o    = err_q;
  // The memory saw address 0 for a suppressed read, so its data must not leak out.
  assign rdata_o  = (|rd_q && !oor_q) ? mem_data_i : '0;

endmodule
